// File: rtl/lock_code_checker.sv
// lock_code_checker: checks keypad digits against the stored code and drives unlock/err.
// Define CHK_LOCKOUT_EN to refuse entry for LOCKOUT_CYC cycles after MAX_FAIL consecutive failures.
module lock_code_checker #(
  parameter int NUM_DIGITS  = 4,
  parameter int DW          = 4,
  parameter int OPEN_CYC    = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 64,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int FW = $clog2(MAX_FAIL + 1),
  localparam int TW = $clog2((OPEN_CYC > LOCKOUT_CYC ? OPEN_CYC : LOCKOUT_CYC) + 1)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_DIGITS*DW-1:0] code,
  input  logic [DW-1:0]            din,
  input  logic                     din_vld,
  input  logic                     cancel,
  output logic                     unlock,
  output logic                     err,
  output logic                     locked_out,
  output logic                     busy,
  output logic [CW-1:0]            digit_cnt
);
  typedef enum logic [2:0] {IDLE, ENTER, OPEN, FAIL, LOCKOUT} state_t;
  state_t state;
  logic mis;
  logic [FW-1:0] fails;
  logic [TW-1:0] tmr;
  logic bad, last;
  logic [FW-1:0] fails_nx;
  assign bad = din != code[int'(digit_cnt)*DW +: DW];
  assign last = digit_cnt == CW'(NUM_DIGITS - 1);
  assign fails_nx = (fails == FW'(MAX_FAIL)) ? fails : fails + 1'b1;
`ifdef CHK_LOCKOUT_EN
  assign locked_out = state == LOCKOUT;
`else
  assign locked_out = 1'b0;
`endif
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      unlock    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      digit_cnt <= '0;
      mis       <= 1'b0;
      fails     <= '0;
      tmr       <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, ENTER: begin
          // cancel outranks a digit arriving in the same cycle
          if (cancel) begin
            state     <= IDLE;
            digit_cnt <= '0;
            mis       <= 1'b0;
            busy      <= 1'b0;
          end else if (din_vld) begin
            if (last) begin
              digit_cnt <= '0;
              mis       <= 1'b0;
              busy      <= 1'b0;
              if (mis || bad) begin
                state <= FAIL;
                err   <= 1'b1;
              end else begin
                state  <= OPEN;
                unlock <= 1'b1;
                fails  <= '0;
                tmr    <= TW'(OPEN_CYC - 1);
              end
            end else begin
              state     <= ENTER;
              digit_cnt <= digit_cnt + 1'b1;
              mis       <= mis | bad;
              busy      <= 1'b1;
            end
          end
        end
        OPEN: begin
          if (cancel || tmr == '0) begin
            state  <= IDLE;
            unlock <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        FAIL: begin
          fails <= fails_nx;
          state <= IDLE;
`ifdef CHK_LOCKOUT_EN
          if (fails_nx == FW'(MAX_FAIL)) begin
            state <= LOCKOUT;
            tmr   <= TW'(LOCKOUT_CYC - 1);
          end
`endif
        end
`ifdef CHK_LOCKOUT_EN
        LOCKOUT: begin
          if (tmr == '0) begin
            state <= IDLE;
            fails <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_code_checker.sv
// tb_lock_code_checker: directed entries; unlock/err/locked_out pulses checked against a queue of expected pulses.
module tb_lock_code_checker;
  logic clk = 1'b0;
  logic clr;
  logic [15:0] code;
  logic [3:0] din;
  logic din_vld, cancel;
  logic unlock, err, locked_out, busy;
  logic [2:0] digit_cnt;
  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  typedef struct {int kind; int len; int st;} ev_t;
  ev_t q[$];
  int plen[3] = '{0, 0, 0};
  int pst[3] = '{0, 0, 0};
  string kname[3] = '{"unlock", "err", "locked_out"};

  lock_code_checker dut (
    .clk(clk), .clr(clr), .code(code), .din(din), .din_vld(din_vld), .cancel(cancel),
    .unlock(unlock), .err(err), .locked_out(locked_out), .busy(busy), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a != e) begin
      nfail++;
      $display("FAIL %s act=%0d exp=%0d", n, a, e);
    end
  endtask

  // Monitor: each finished pulse is compared with the oldest expected pulse
  always @(negedge clk) begin
    logic [2:0] lv;
    lv = {locked_out, err, unlock};
    for (int k = 0; k < 3; k++) begin
      if (lv[k]) begin
        if (plen[k] == 0) pst[k] = cyc;
        plen[k]++;
      end else if (plen[k] > 0) begin
        nchk++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_%s len=%0d start=%0d", kname[k], plen[k], pst[k]);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.kind != k || e.len != plen[k] || e.st != pst[k]) begin
            nfail++;
            $display("FAIL pulse act=%s/len%0d/at%0d exp=%s/len%0d/at%0d",
                     kname[k], plen[k], pst[k], kname[e.kind], e.len, e.st);
          end
        end
        plen[k] = 0;
      end
    end
  end

  task automatic dig(input logic [3:0] d, input logic c = 1'b0);
    @(negedge clk);
    din = d;
    din_vld = 1'b1;
    cancel = c;
    @(posedge clk);
    #1 din_vld = 1'b0;
    cancel = 1'b0;
  endtask

  // digits taken low nibble first; kind 0=unlock 1=err, len = expected pulse length
  task automatic entry(input logic [15:0] ds, input int kind, input int len);
    for (int i = 0; i < 4; i++) begin
      dig(ds[i*4 +: 4]);
      chk("digit_cnt", int'(digit_cnt), (i == 3) ? 0 : i + 1);
      if (i == 0) chk("busy_first", int'(busy), 1);
    end
    chk("busy_last", int'(busy), 0);
    q.push_back('{kind, len, cyc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0;
    code = 16'h4321;
    din = '0;
    din_vld = 1'b0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_locked_out", int'(locked_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    clr = 1'b1;
    entry(16'h4321, 0, 16);
    repeat (18) @(negedge clk);
    entry(16'h4391, 1, 1);
    repeat (3) @(negedge clk);
    dig(4'd1);
    dig(4'd2);
    chk("cnt_before_cancel", int'(digit_cnt), 2);
    dig(4'd3, 1'b1);
    chk("cnt_after_cancel", int'(digit_cnt), 0);
    chk("busy_after_cancel", int'(busy), 0);
    dig(4'd1, 1'b1);
    chk("cnt_idle_cancel_din", int'(digit_cnt), 0);
    entry(16'h4321, 0, 16);
    repeat (18) @(negedge clk);
    entry(16'h4321, 0, 5);
    dig(4'd1);
    dig(4'd2);
    chk("cnt_open_ignored", int'(digit_cnt), 0);
    chk("unlock_held", int'(unlock), 1);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("unlock_after_cancel", int'(unlock), 0);
    repeat (2) @(negedge clk);
`ifdef CHK_LOCKOUT_EN
    for (int n = 0; n < 3; n++) begin
      entry(16'h4325, 1, 1);
      if (n < 2) repeat (2) @(negedge clk);
    end
    q.push_back('{2, 64, cyc + 1});
    dig(4'd1);
    dig(4'd1);
    dig(4'd2, 1'b1);
    chk("lockout_active", int'(locked_out), 1);
    chk("cnt_lockout_ignored", int'(digit_cnt), 0);
    repeat (70) @(negedge clk);
    chk("lockout_over", int'(locked_out), 0);
    entry(16'h4321, 0, 16);
    repeat (18) @(negedge clk);
`else
    for (int n = 0; n < 5; n++) begin
      entry(16'h4325, 1, 1);
      repeat (2) @(negedge clk);
      chk("no_lockout", int'(locked_out), 0);
    end
`endif
    dig(4'd1);
    dig(4'd2);
    @(negedge clk);
    #1 clr = 1'b0;
    #1 chk("clr_enter_cnt", int'(digit_cnt), 0);
    chk("clr_enter_busy", int'(busy), 0);
    @(negedge clk);
    clr = 1'b1;
    entry(16'h4321, 0, 3);
    repeat (3) @(negedge clk);
    #1 clr = 1'b0;
    #1 chk("clr_open_unlock", int'(unlock), 0);
    @(negedge clk);
    clr = 1'b1;
    entry(16'h4321, 0, 16);
    for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pending_pulses", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
